peripheral_msi_slave_port_tl: RTL and testbench
===============================================

PERIPHERAL_MSI_SLAVE_PORT_TL -- requirements
Module: peripheral_msi_slave_port_tl

Interface
REQ-001 SHALL have parameter PLEN, default 64, address width.
REQ-002 SHALL have parameter XLEN, default 64, data width.
REQ-003 SHALL have parameter MASTERS, default 5, number of master ports competing for this slave.
REQ-004 SHALL have one clock and a synchronous, active-high reset, as the following two port lines state.
REQ-005 HCLK  input  1  single clock; all state updates on rising edge.
REQ-006 HRESET  input  1  reset, synchronous, active-high.
REQ-007 mst_priority  input  MASTERS x 3  per-master request priority; 7 is highest.
REQ-008 mst_HSEL  input  MASTERS  per-master request for this slave, driven by that master port's slvHSEL bit.
REQ-009 mst_HADDR/HWDATA/HWRITE/HSIZE/HBURST/HPROT/HTRANS/HMASTLOCK  input  MASTERS x (PLEN/XLEN/1/3/3/4/2/1)  per-master AHB address- and data-phase signals.
REQ-010 mst_HREADY  input  MASTERS  per-master HREADY, driven by that master port's slvHREADYOUT.
REQ-011 can_switch  input  MASTERS  per-master release flag; the master may lose the bus next cycle.
REQ-012 master_granted  output  MASTERS  one-hot registered grant vector; all-zero means no grant.
REQ-013 mst_HRDATA  output  XLEN  slave read data, broadcast to all masters.
REQ-014 mst_HREADYOUT  output  1  ready for the data-phase master.
REQ-015 mst_HRESP  output  1  response for the data-phase master.
REQ-016 slv_HSEL, slv_HADDR, slv_HWDATA, slv_HWRITE, slv_HSIZE, slv_HBURST, slv_HPROT, slv_HTRANS, slv_HMASTLOCK  output  1/PLEN/XLEN/1/3/3/4/2/1  AHB outputs to the slave.
REQ-017 slv_HREADYOUT  output  1  HREADY to the slave.
REQ-018 slv_HREADY  input  1  slave HREADYOUT.
REQ-019 slv_HRESP  input  1  slave HRESP.
REQ-020 slv_HRDATA  input  XLEN  slave HRDATA.

Function
REQ-021 SHALL evaluate arbitration every cycle; the new master_granted SHALL take effect on the next rising edge (1-cycle latency).
REQ-022 SHALL update master_granted only when slv_HREADY=1 and (master_granted==0 or can_switch[granted]=1); otherwise it SHALL hold.
REQ-023 On an update, SHALL select, among masters with mst_HSEL=1, the highest mst_priority; ties SHALL be broken round-robin starting at index (last granted + 1) mod MASTERS.
REQ-024 On an update with no requester, SHALL clear master_granted to 0.
REQ-025 A current master that is still requesting, with can_switch=0, SHALL keep the grant regardless of higher-priority requests (lock and burst protection).
REQ-026 With a grant, address-phase outputs slv_* SHALL be muxed combinationally from the granted master, with slv_HSEL=mst_HSEL[granted].
REQ-027 With no grant, SHALL drive slv_HSEL=0, slv_HTRANS=IDLE, and the other address-phase outputs 0.
REQ-028 SHALL keep a data-phase owner register (index plus valid); on slv_HREADY=1 it SHALL load the granted index, with valid=slv_HSEL & (slv_HTRANS!=IDLE).
REQ-029 slv_HWDATA SHALL be muxed from the data-phase owner.
REQ-030 slv_HREADYOUT SHALL be mst_HREADY[owner] when valid, else 1.
REQ-031 mst_HREADYOUT SHALL be slv_HREADY when owner valid, else 1; mst_HRESP SHALL be slv_HRESP when valid, else OKAY.
REQ-032 Grant change and data-phase hand-over in the same cycle SHALL be legal: the address phase goes to the new master while HWDATA comes from the previous one.
REQ-033 A master with an out-of-range mst_priority SHALL NOT exist (3 bits); MASTERS=1 SHALL degenerate to grant-on-request.

Reset
REQ-034 While HRESET=1 at a clock edge, SHALL clear master_granted to 0, data-phase valid to 0, and the round-robin pointer to index MASTERS-1, so that master 0 wins the first tie.
REQ-035 After reset, outputs SHALL be slv_HSEL=0, slv_HTRANS=IDLE, slv_HREADYOUT=1, mst_HREADYOUT=1, mst_HRESP=OKAY.
REQ-036 A reset mid-burst SHALL abandon the burst with no pending grant retained.

Structure
REQ-037 HTRANS_*, HBURST_*, HRESP_* constants SHALL come from the shared peripheral_biu_pkg; this block SHALL add no local copies.
REQ-038 The priority plus round-robin selection SHALL be one sub-module, peripheral_msi_arbiter_tl (inputs: requests, priorities, last grant; output: one-hot).

Verification
REQ-039 Reset, then M0 HSEL=1 NONSEQ SINGLE priority 2 -> master_granted=00001 one cycle later; slv_HTRANS=NONSEQ from M0.
REQ-040 M1 priority 5 and M3 priority 2 request together, no grant -> master_granted=00010.
REQ-041 M2 and M4 at equal priority 3 re-request repeatedly with can_switch=1 -> grant alternates 00100, 10000, 00100.
REQ-042 M0 has the grant, locked, can_switch=0; M1 requests at priority 7 -> grant stays 00001 until can_switch=1, then 00010 next cycle.
REQ-043 Slave inserts 2 wait states (slv_HREADY=0) during a grant change -> master_granted held; mst_HREADYOUT=0 for 2 cycles; HWDATA from the old owner.
REQ-044 HRESET=1 asserted mid INCR4 burst -> next cycle master_granted=0, slv_HTRANS=IDLE, mst_HREADYOUT=1.

Source files
------------

// File: rtl/peripheral_biu_pkg.sv
// Shared AHB encodings for the bus-interface blocks.
// Arbitration-related slices import these instead of keeping their own copies.
package peripheral_biu_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef logic [2:0] prio_t;

endpackage

// File: rtl/peripheral_msi_arbiter_tl.sv
// Priority arbiter with round-robin tie-break among equal-priority requesters.
// Search starts one past the last granted index; output is one-hot or zero.
module peripheral_msi_arbiter_tl
  import peripheral_biu_pkg::*;
#(
  parameter int MASTERS = 5,
  parameter int IDX_W   = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
  input  logic [MASTERS-1:0]        req,
  input  prio_t [MASTERS-1:0]       pri,
  input  logic [IDX_W-1:0]          last,
  output logic [MASTERS-1:0]        grant
);

  prio_t            top_pri;
  logic             found;
  int               pos;
  logic [IDX_W-1:0] idx;

  always_comb begin
    top_pri = '0;
    found   = 1'b0;
    pos     = 0;
    idx     = '0;
    grant   = '0;
    for (int i = 0; i < MASTERS; i++) begin
      if (req[i] && (pri[i] > top_pri)) top_pri = pri[i];
    end
    // First requester at the winning priority, walking from last+1 with wrap.
    for (int k = 1; k <= MASTERS; k++) begin
      pos = int'(last) + k;
      if (pos >= MASTERS) pos = pos - MASTERS;
      idx = IDX_W'(pos);
      if (!found && req[idx] && (pri[idx] == top_pri)) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/peripheral_msi_slave_port_tl.sv
// Slave-side port of the multi-layer interconnect: arbitrates the competing
// masters, muxes the address phase from the grant and the data phase from the owner.
module peripheral_msi_slave_port_tl
  import peripheral_biu_pkg::*;
#(
  parameter int PLEN    = 64,
  parameter int XLEN    = 64,
  parameter int MASTERS = 5
) (
  input  logic                          HCLK,
  input  logic                          HRESET,
  input  prio_t [MASTERS-1:0]           mst_priority,
  input  logic [MASTERS-1:0]            mst_HSEL,
  input  logic [MASTERS-1:0][PLEN-1:0]  mst_HADDR,
  input  logic [MASTERS-1:0][XLEN-1:0]  mst_HWDATA,
  input  logic [MASTERS-1:0]            mst_HWRITE,
  input  logic [MASTERS-1:0][2:0]       mst_HSIZE,
  input  logic [MASTERS-1:0][2:0]       mst_HBURST,
  input  logic [MASTERS-1:0][3:0]       mst_HPROT,
  input  logic [MASTERS-1:0][1:0]       mst_HTRANS,
  input  logic [MASTERS-1:0]            mst_HMASTLOCK,
  input  logic [MASTERS-1:0]            mst_HREADY,
  input  logic [MASTERS-1:0]            can_switch,
  output logic [MASTERS-1:0]            master_granted,
  output logic [XLEN-1:0]               mst_HRDATA,
  output logic                          mst_HREADYOUT,
  output logic                          mst_HRESP,
  output logic                          slv_HSEL,
  output logic [PLEN-1:0]               slv_HADDR,
  output logic [XLEN-1:0]               slv_HWDATA,
  output logic                          slv_HWRITE,
  output logic [2:0]                    slv_HSIZE,
  output logic [2:0]                    slv_HBURST,
  output logic [3:0]                    slv_HPROT,
  output logic [1:0]                    slv_HTRANS,
  output logic                          slv_HMASTLOCK,
  output logic                          slv_HREADYOUT,
  input  logic                          slv_HREADY,
  input  logic                          slv_HRESP,
  input  logic [XLEN-1:0]               slv_HRDATA
);

  localparam int IDX_W = (MASTERS > 1) ? $clog2(MASTERS) : 1;

  function automatic logic [IDX_W-1:0] onehot_idx(input logic [MASTERS-1:0] oh);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MASTERS; i++) begin
      if (oh[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  logic [MASTERS-1:0] arb_grant;
  logic [IDX_W-1:0]   last_idx;
  logic [IDX_W-1:0]   gnt_idx;
  logic [IDX_W-1:0]   dph_idx_p1;
  logic               vld_p1;
  logic               upd;

  peripheral_msi_arbiter_tl #(
    .MASTERS (MASTERS),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req   (mst_HSEL),
    .pri   (mst_priority),
    .last  (last_idx),
    .grant (arb_grant)
  );

  assign gnt_idx = onehot_idx(master_granted);
  // A held grant only moves when the slave is ready and the owner allows release.
  assign upd     = slv_HREADY && ((master_granted == '0) || can_switch[gnt_idx]);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      master_granted <= '0;
      last_idx       <= IDX_W'(MASTERS - 1);
      vld_p1         <= 1'b0;
      dph_idx_p1     <= '0;
    end else begin
      if (upd) begin
        master_granted <= arb_grant;
        if (|arb_grant) last_idx <= onehot_idx(arb_grant);
      end
      if (slv_HREADY) begin
        dph_idx_p1 <= gnt_idx;
        vld_p1     <= slv_HSEL && (slv_HTRANS != HTRANS_IDLE);
      end
    end
  end

  // Address phase: combinational mux from the current grant.
  always_comb begin
    slv_HSEL      = 1'b0;
    slv_HADDR     = '0;
    slv_HWRITE    = 1'b0;
    slv_HSIZE     = '0;
    slv_HBURST    = HBURST_SINGLE;
    slv_HPROT     = '0;
    slv_HTRANS    = HTRANS_IDLE;
    slv_HMASTLOCK = 1'b0;
    if (|master_granted) begin
      slv_HSEL      = mst_HSEL[gnt_idx];
      slv_HADDR     = mst_HADDR[gnt_idx];
      slv_HWRITE    = mst_HWRITE[gnt_idx];
      slv_HSIZE     = mst_HSIZE[gnt_idx];
      slv_HBURST    = mst_HBURST[gnt_idx];
      slv_HPROT     = mst_HPROT[gnt_idx];
      slv_HTRANS    = mst_HTRANS[gnt_idx];
      slv_HMASTLOCK = mst_HMASTLOCK[gnt_idx];
    end
  end

  // Data phase: follows the registered owner, which may differ from the grant.
  assign slv_HWDATA    = mst_HWDATA[dph_idx_p1];
  assign slv_HREADYOUT = vld_p1 ? mst_HREADY[dph_idx_p1] : 1'b1;
  assign mst_HREADYOUT = vld_p1 ? slv_HREADY : 1'b1;
  assign mst_HRESP     = vld_p1 ? slv_HRESP : HRESP_OKAY;
  assign mst_HRDATA    = slv_HRDATA;

endmodule

// File: tb/tb_peripheral_msi_slave_port_tl.sv
// Bench for the slave-port arbiter: random and directed traffic against a
// behavioural model, with expected responses queued for a separate monitor.
module tb_peripheral_msi_slave_port_tl;
  import peripheral_biu_pkg::*;

  localparam int M  = 5;
  localparam int PL = 64;
  localparam int XL = 64;

  typedef struct packed {
    logic                 rst;
    logic [M-1:0][2:0]    pri;
    logic [M-1:0]         hsel;
    logic [M-1:0][PL-1:0] haddr;
    logic [M-1:0][XL-1:0] hwdata;
    logic [M-1:0]         hwrite;
    logic [M-1:0][2:0]    hsize;
    logic [M-1:0][2:0]    hburst;
    logic [M-1:0][3:0]    hprot;
    logic [M-1:0][1:0]    htrans;
    logic [M-1:0]         hlock;
    logic [M-1:0]         mhready;
    logic [M-1:0]         cansw;
    logic                 shready;
    logic                 shresp;
    logic [XL-1:0]        shrdata;
  } stim_t;

  typedef struct packed {
    logic [M-1:0]  gnt;
    logic          hsel;
    logic [1:0]    htrans;
    logic [PL-1:0] haddr;
    logic          hwrite;
    logic          chk_wd;
    logic [XL-1:0] hwdata;
    logic          s_hreadyout;
    logic          m_hreadyout;
    logic          m_hresp;
    logic [XL-1:0] hrdata;
  } exp_t;

  logic HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  stim_t cur, nx;
  exp_t  exp_q[$];

  logic [M-1:0]  master_granted;
  logic [XL-1:0] mst_HRDATA;
  logic          mst_HREADYOUT, mst_HRESP;
  logic          slv_HSEL, slv_HWRITE, slv_HMASTLOCK, slv_HREADYOUT;
  logic [PL-1:0] slv_HADDR;
  logic [XL-1:0] slv_HWDATA;
  logic [2:0]    slv_HSIZE, slv_HBURST;
  logic [3:0]    slv_HPROT;
  logic [1:0]    slv_HTRANS;

  peripheral_msi_slave_port_tl #(.PLEN(PL), .XLEN(XL), .MASTERS(M)) dut (
    .HCLK          (HCLK),
    .HRESET        (cur.rst),
    .mst_priority  (cur.pri),
    .mst_HSEL      (cur.hsel),
    .mst_HADDR     (cur.haddr),
    .mst_HWDATA    (cur.hwdata),
    .mst_HWRITE    (cur.hwrite),
    .mst_HSIZE     (cur.hsize),
    .mst_HBURST    (cur.hburst),
    .mst_HPROT     (cur.hprot),
    .mst_HTRANS    (cur.htrans),
    .mst_HMASTLOCK (cur.hlock),
    .mst_HREADY    (cur.mhready),
    .can_switch    (cur.cansw),
    .master_granted(master_granted),
    .mst_HRDATA    (mst_HRDATA),
    .mst_HREADYOUT (mst_HREADYOUT),
    .mst_HRESP     (mst_HRESP),
    .slv_HSEL      (slv_HSEL),
    .slv_HADDR     (slv_HADDR),
    .slv_HWDATA    (slv_HWDATA),
    .slv_HWRITE    (slv_HWRITE),
    .slv_HSIZE     (slv_HSIZE),
    .slv_HBURST    (slv_HBURST),
    .slv_HPROT     (slv_HPROT),
    .slv_HTRANS    (slv_HTRANS),
    .slv_HMASTLOCK (slv_HMASTLOCK),
    .slv_HREADYOUT (slv_HREADYOUT),
    .slv_HREADY    (cur.shready),
    .slv_HRESP     (cur.shresp),
    .slv_HRDATA    (cur.shrdata)
  );

  int total = 0;
  int bad   = 0;

  // Model state: current grant (-1 = none), last winner, data-phase owner.
  int m_gnt, m_last, m_own;
  bit m_own_v;
  bit model_ok = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, req);
    end
  endtask

  task automatic idle_stim();
    nx         = '0;
    nx.shready = 1'b1;
    nx.mhready = '1;
  endtask

  task automatic rnd_stim();
    nx.rst = ($urandom_range(63) == 0);
    for (int i = 0; i < M; i++) begin
      nx.pri[i]     = 3'($urandom_range(7));
      nx.hsel[i]    = 1'($urandom_range(1));
      nx.haddr[i]   = {$urandom, $urandom};
      nx.hwdata[i]  = {$urandom, $urandom};
      nx.hwrite[i]  = 1'($urandom_range(1));
      nx.hsize[i]   = 3'($urandom_range(7));
      nx.hburst[i]  = 3'($urandom_range(7));
      nx.hprot[i]   = 4'($urandom_range(15));
      nx.htrans[i]  = 2'($urandom_range(3));
      nx.hlock[i]   = 1'($urandom_range(1));
      nx.mhready[i] = ($urandom_range(3) != 0);
      nx.cansw[i]   = ($urandom_range(3) != 0);
    end
    nx.shready = ($urandom_range(3) != 0);
    nx.shresp  = ($urandom_range(7) == 0);
    nx.shrdata = {$urandom, $urandom};
  endtask

  // One bus cycle: apply stimulus, queue the expected outputs, advance the model.
  task automatic cyc();
    exp_t e;
    int   win, bp, bd, d;
    @(posedge HCLK);
    #1;
    cur = nx;
    if (model_ok) begin
      e             = '0;
      if (m_gnt >= 0) begin
        e.gnt[m_gnt] = 1'b1;
        e.hsel       = cur.hsel[m_gnt];
        e.htrans     = cur.htrans[m_gnt];
        e.haddr      = cur.haddr[m_gnt];
        e.hwrite     = cur.hwrite[m_gnt];
      end
      e.chk_wd      = m_own_v;
      e.hwdata      = m_own_v ? cur.hwdata[m_own] : '0;
      e.s_hreadyout = m_own_v ? cur.mhready[m_own] : 1'b1;
      e.m_hreadyout = m_own_v ? cur.shready : 1'b1;
      e.m_hresp     = m_own_v ? cur.shresp : HRESP_OKAY;
      e.hrdata      = cur.shrdata;
      exp_q.push_back(e);
    end
    if (cur.rst) begin
      m_gnt = -1; m_last = M - 1; m_own = 0; m_own_v = 1'b0; model_ok = 1'b1;
    end else if (model_ok) begin
      if (cur.shready) begin
        m_own_v = (m_gnt >= 0) && cur.hsel[m_gnt] && (cur.htrans[m_gnt] != HTRANS_IDLE);
        m_own   = (m_gnt >= 0) ? m_gnt : 0;
      end
      if (cur.shready && (m_gnt < 0 || cur.cansw[m_gnt])) begin
        win = -1; bp = -1; bd = M;
        for (int i = 0; i < M; i++) begin
          if (cur.hsel[i]) begin
            d = (i - m_last - 1 + 2 * M) % M;
            if (int'(cur.pri[i]) > bp || (int'(cur.pri[i]) == bp && d < bd)) begin
              win = i; bp = int'(cur.pri[i]); bd = d;
            end
          end
        end
        m_gnt = win;
        if (win >= 0) m_last = win;
      end
    end
  endtask

  task automatic do_reset();
    idle_stim();
    nx.rst = 1'b1;
    cyc();
    nx.rst = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge HCLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("grant", 128'(master_granted), 128'(e.gnt));
        chk("slv_hsel", 128'(slv_HSEL), 128'(e.hsel));
        chk("slv_htrans", 128'(slv_HTRANS), 128'(e.htrans));
        chk("slv_haddr", 128'(slv_HADDR), 128'(e.haddr));
        chk("slv_hwrite", 128'(slv_HWRITE), 128'(e.hwrite));
        if (e.chk_wd) chk("slv_hwdata", 128'(slv_HWDATA), 128'(e.hwdata));
        chk("slv_hreadyout", 128'(slv_HREADYOUT), 128'(e.s_hreadyout));
        chk("mst_hreadyout", 128'(mst_HREADYOUT), 128'(e.m_hreadyout));
        chk("mst_hresp", 128'(mst_HRESP), 128'(e.m_hresp));
        chk("mst_hrdata", 128'(mst_HRDATA), 128'(e.hrdata));
      end
    end
  end

  initial begin : stimulus
    logic [XL-1:0] wd0;
    cur = '0;
    nx  = '0;
    cur.rst = 1'b1;

    // Reset state
    do_reset();
    cyc();
    @(negedge HCLK);
    chk("rst_grant", 128'(master_granted), 128'(0));
    chk("rst_hsel", 128'(slv_HSEL), 128'(0));
    chk("rst_htrans", 128'(slv_HTRANS), 128'(HTRANS_IDLE));
    chk("rst_s_hreadyout", 128'(slv_HREADYOUT), 128'(1));
    chk("rst_m_hreadyout", 128'(mst_HREADYOUT), 128'(1));
    chk("rst_hresp", 128'(mst_HRESP), 128'(HRESP_OKAY));

    // Single requester gets the grant one cycle later
    do_reset();
    nx.hsel[0] = 1'b1; nx.htrans[0] = HTRANS_NONSEQ; nx.pri[0] = 3'd2;
    cyc();
    @(negedge HCLK);
    chk("m0_no_grant_yet", 128'(master_granted), 128'(0));
    cyc();
    @(negedge HCLK);
    chk("m0_grant", 128'(master_granted), 128'(5'b00001));
    chk("m0_htrans", 128'(slv_HTRANS), 128'(HTRANS_NONSEQ));

    // Higher priority wins
    do_reset();
    nx.hsel[1] = 1'b1; nx.pri[1] = 3'd5; nx.htrans[1] = HTRANS_NONSEQ;
    nx.hsel[3] = 1'b1; nx.pri[3] = 3'd2; nx.htrans[3] = HTRANS_NONSEQ;
    cyc(); cyc();
    @(negedge HCLK);
    chk("pri_grant", 128'(master_granted), 128'(5'b00010));

    // Equal priorities alternate round-robin
    do_reset();
    nx.cansw = '1;
    nx.hsel[2] = 1'b1; nx.pri[2] = 3'd3; nx.htrans[2] = HTRANS_NONSEQ;
    nx.hsel[4] = 1'b1; nx.pri[4] = 3'd3; nx.htrans[4] = HTRANS_NONSEQ;
    cyc(); cyc();
    @(negedge HCLK);
    chk("rr_1", 128'(master_granted), 128'(5'b00100));
    cyc();
    @(negedge HCLK);
    chk("rr_2", 128'(master_granted), 128'(5'b10000));
    cyc();
    @(negedge HCLK);
    chk("rr_3", 128'(master_granted), 128'(5'b00100));

    // Locked owner keeps the bus against a priority-7 request
    do_reset();
    nx.hsel[0] = 1'b1; nx.hlock[0] = 1'b1; nx.htrans[0] = HTRANS_NONSEQ;
    cyc(); cyc();
    nx.hsel[1] = 1'b1; nx.pri[1] = 3'd7; nx.htrans[1] = HTRANS_NONSEQ;
    for (int k = 0; k < 3; k++) begin
      cyc();
      @(negedge HCLK);
      chk("lock_hold", 128'(master_granted), 128'(5'b00001));
    end
    nx.cansw[0] = 1'b1;
    cyc();
    @(negedge HCLK);
    chk("lock_release_same", 128'(master_granted), 128'(5'b00001));
    cyc();
    @(negedge HCLK);
    chk("lock_release_next", 128'(master_granted), 128'(5'b00010));

    // Wait states during a grant change; data phase stays with the old owner
    do_reset();
    wd0 = {$urandom, $urandom};
    nx.hsel[0] = 1'b1; nx.htrans[0] = HTRANS_NONSEQ; nx.hwrite[0] = 1'b1;
    nx.pri[0] = 3'd1; nx.hwdata[0] = wd0;
    cyc(); cyc(); cyc();
    nx.hsel[1] = 1'b1; nx.pri[1] = 3'd7; nx.htrans[1] = HTRANS_NONSEQ;
    nx.haddr[1] = 64'h1000; nx.hwdata[1] = ~wd0;
    nx.cansw[0] = 1'b1; nx.shready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cyc();
      @(negedge HCLK);
      chk("ws_grant", 128'(master_granted), 128'(5'b00001));
      chk("ws_m_hreadyout", 128'(mst_HREADYOUT), 128'(0));
      chk("ws_hwdata", 128'(slv_HWDATA), 128'(wd0));
    end
    nx.shready = 1'b1;
    cyc();
    @(negedge HCLK);
    chk("ws_end_hreadyout", 128'(mst_HREADYOUT), 128'(1));
    cyc();
    @(negedge HCLK);
    chk("handover_grant", 128'(master_granted), 128'(5'b00010));
    chk("handover_haddr", 128'(slv_HADDR), 128'(64'h1000));
    chk("handover_hwdata", 128'(slv_HWDATA), 128'(wd0));

    // Reset in the middle of an INCR4 burst
    do_reset();
    nx.hsel[0] = 1'b1; nx.htrans[0] = HTRANS_NONSEQ; nx.hburst[0] = HBURST_INCR4;
    cyc(); cyc();
    nx.htrans[0] = HTRANS_SEQ;
    cyc();
    @(negedge HCLK);
    chk("burst_grant", 128'(master_granted), 128'(5'b00001));
    nx.rst = 1'b1;
    cyc();
    nx.rst = 1'b0;
    cyc();
    @(negedge HCLK);
    chk("burst_rst_grant", 128'(master_granted), 128'(0));
    chk("burst_rst_htrans", 128'(slv_HTRANS), 128'(HTRANS_IDLE));
    chk("burst_rst_hreadyout", 128'(mst_HREADYOUT), 128'(1));

    // Random traffic against the model
    for (int n = 0; n < 2000; n++) begin
      rnd_stim();
      cyc();
    end

    idle_stim();
    cyc();
    @(negedge HCLK);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
